// File: rtl/mil_fifo_pkg.sv
// Shared types for the MIL-STD-1553 transmit commit FIFO: packet FSM states and the payload word.
package mil_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef logic [15:0] word_t;

endpackage

// File: rtl/mil_fifo_ram.sv
// Simple dual-port word store: one write port, one synchronous read port with a registered output.
module mil_fifo_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mil_tx_commit_fifo.sv
// Packet-committing FIFO: pushed words stay speculative until pkt_commit, so only good packets
// become visible to the 1553 transmitter pop port.
module mil_tx_commit_fifo
  import mil_fifo_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_request,
  output logic                     push_done,
  input  logic                     pkt_start,
  input  logic                     pkt_commit,
  input  logic                     pkt_abort,
  input  logic                     pop_request,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_done,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     overflow,
  output logic                     stray
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  state_e r_state, w_state_nxt;
  ptr_t   r_wr_ptr, r_commit_ptr, r_rd_ptr;
  ptr_t   w_wr_ptr_nxt, w_commit_ptr_nxt;
  logic   r_push_done, r_pop_done, r_overflow, r_stray;
  logic   w_overflow_nxt, w_stray_nxt;
  logic   w_we, w_full, w_pop_ok;
  ptr_t   w_used;

  // The extra pointer MSB distinguishes a full buffer from an empty one.
  assign w_full   = ((r_wr_ptr - r_rd_ptr) == ptr_t'(DEPTH));
  assign w_used   = r_commit_ptr - r_rd_ptr;
  assign w_pop_ok = pop_request && (w_used != '0);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_overflow_nxt   = r_overflow;
    w_stray_nxt      = r_stray;
    w_we             = 1'b0;

    if (pkt_start) begin
      // A start inside a packet silently abandons it; any push in this cycle is dropped.
      w_wr_ptr_nxt   = r_commit_ptr;
      w_overflow_nxt = 1'b0;
      w_state_nxt    = FILL;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (push_request) w_stray_nxt = 1'b1;
        end
        FILL: begin
          if (pkt_abort) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_state_nxt  = IDLE;
          end else begin
            if (push_request && !w_full) begin
              w_we         = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end else if (push_request) begin
              w_overflow_nxt = 1'b1;
              w_state_nxt    = DROP;
            end
            if (pkt_commit) begin
              if (push_request && w_full) w_wr_ptr_nxt     = r_commit_ptr;
              else                        w_commit_ptr_nxt = w_wr_ptr_nxt;
              w_state_nxt = IDLE;
            end
          end
        end
        DROP: begin
          if (pkt_abort || pkt_commit) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_state_nxt  = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_push_done  <= 1'b0;
      r_pop_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_rd_ptr     <= w_pop_ok ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_push_done  <= push_request;
      r_pop_done   <= w_pop_ok;
      r_overflow   <= w_overflow_nxt;
      r_stray      <= w_stray_nxt;
    end
  end

  mil_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (push_data),
    .i_rd_en   (w_pop_ok),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (pop_data)
  );

  assign push_done = r_push_done;
  assign pop_done  = r_pop_done;
  assign used      = w_used;
  assign overflow  = r_overflow;
  assign stray     = r_stray;

endmodule
